// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-outstanding IF/LSU arbiter onto one memory port, LSU priority.
// Define ARB_STARVE_GUARD_EN to force an IF win after STARVE_LIMIT consecutive IF losses.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_be,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        o_stall_if,
  output logic        o_stall_mem
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t      state_q, state_d;
  logic        owner_lsu_q, owner_lsu_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        arb, win_lsu, force_if;
  assign arb     = state_q == IDLE && (if_req || lsu_req);
  assign win_lsu = lsu_req && !force_if;
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;
  assign force_if = if_req && starve_q == 4'(STARVE_LIMIT);
  always_comb starve_d = !arb ? starve_q : !win_lsu ? 4'd0 : if_req ? starve_q + 4'd1 : starve_q;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) starve_q <= 4'd0;
    else         starve_q <= starve_d;
`else
  logic unused_limit;
  assign unused_limit = ^STARVE_LIMIT;
  assign force_if = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    if_gnt      = 1'b0;
    lsu_gnt     = 1'b0;
    if (arb) begin
      state_d     = REQ;
      owner_lsu_d = win_lsu;
      we_d        = win_lsu && lsu_we;
      addr_d      = win_lsu ? lsu_addr : if_addr;
      wdata_d     = win_lsu ? lsu_wdata : 32'h0;
      be_d        = win_lsu ? lsu_be : 4'hF;
      lsu_gnt     = win_lsu;
      if_gnt      = !win_lsu;
    end else if (state_q == REQ && mem_gnt) begin
      state_d = RESP;
    end else if (state_q == RESP && mem_rvalid) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q     <= IDLE;
      owner_lsu_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  assign mem_req     = state_q == REQ;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign if_rvalid   = state_q == RESP && mem_rvalid && !owner_lsu_q;
  assign lsu_rvalid  = state_q == RESP && mem_rvalid && owner_lsu_q;
  assign if_rdata    = mem_rdata;
  assign lsu_rdata   = mem_rdata;
  assign o_stall_if  = if_req && !if_rvalid;
  assign o_stall_mem = (lsu_req || (owner_lsu_q && state_q != IDLE)) && !lsu_rvalid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus reset and starvation sequences.
module tb_mem_port_arbiter;
  logic        i_clk = 1'b0, i_reset = 1'b1;
  logic        if_req = 1'b0, lsu_req = 1'b0, lsu_we = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] if_addr = 32'h100, lsu_addr = 32'h200, lsu_wdata = 32'h55AA, mem_rdata = 32'hDEADBEEF;
  logic [3:0]  lsu_be = 4'h3;
  logic        if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, o_stall_if, o_stall_mem;
  logic [31:0] if_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int checks = 0, errors = 0;

  mem_port_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_be(lsu_be),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem)
  );

  always #5 i_clk = ~i_clk;

  // in = {if_req, lsu_req, lsu_we, mem_gnt, mem_rvalid}
  // f  = {if_gnt, lsu_gnt, mem_req, if_rvalid, lsu_rvalid, mem_we, o_stall_if, o_stall_mem}
  typedef struct packed {
    logic [4:0]  in;
    logic [7:0]  f;
    logic [3:0]  be;
    logic [31:0] a;
  } vec_t;
  vec_t vt [18];

  function automatic logic [7:0] flags();
    return {if_gnt, lsu_gnt, mem_req, if_rvalid, lsu_rvalid, mem_we, o_stall_if, o_stall_mem};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vt[0]  = '{5'b00001, 8'b00000000, 4'h0, 32'h0};
    vt[1]  = '{5'b10000, 8'b10000010, 4'h0, 32'h0};
    vt[2]  = '{5'b00010, 8'b00100000, 4'hF, 32'h100};
    vt[3]  = '{5'b00001, 8'b00010000, 4'hF, 32'h100};
    vt[4]  = '{5'b11100, 8'b01000011, 4'hF, 32'h100};
    vt[5]  = '{5'b10010, 8'b00100111, 4'h3, 32'h200};
    vt[6]  = '{5'b10001, 8'b00001110, 4'h3, 32'h200};
    vt[7]  = '{5'b10000, 8'b10000110, 4'h3, 32'h200};
    for (int i = 8; i < 13; i++) vt[i] = '{5'b10000, 8'b00100010, 4'hF, 32'h100};
    vt[13] = '{5'b10010, 8'b00100010, 4'hF, 32'h100};
    vt[14] = '{5'b10000, 8'b00000010, 4'hF, 32'h100};
    vt[15] = '{5'b10001, 8'b00010000, 4'hF, 32'h100};
    vt[16] = '{5'b00010, 8'b00000000, 4'hF, 32'h100};
    vt[17] = '{5'b00000, 8'b00000000, 4'hF, 32'h100};
    @(negedge i_clk);
    chk("reset_outputs", {flags(), mem_be, mem_addr}, 64'h0);
    chk("reset_wdata", 64'(mem_wdata), 64'h0);
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      {if_req, lsu_req, lsu_we, mem_gnt, mem_rvalid} = vt[i].in;
      #1;
      chk($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vt[i].f));
      chk($sformatf("vec%0d_be", i), 64'(mem_be), 64'(vt[i].be));
      chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vt[i].a));
      if (vt[i].f[4]) chk($sformatf("vec%0d_if_rdata", i), 64'(if_rdata), 64'hDEADBEEF);
      if (vt[i].f[3]) chk($sformatf("vec%0d_lsu_rdata", i), 64'(lsu_rdata), 64'hDEADBEEF);
      if (i == 5) chk("store_wdata", 64'(mem_wdata), 64'h55AA);
      @(negedge i_clk);
    end
    {if_req, lsu_req, lsu_we, mem_gnt, mem_rvalid} = 5'b0;
    // Reset while waiting in RESP, then a stray response must be ignored.
    lsu_req = 1'b1;
    #1 chk("rst_seq_gnt", 64'({if_gnt, lsu_gnt}), 64'b01);
    @(negedge i_clk);
    lsu_req = 1'b0; mem_gnt = 1'b1;
    @(negedge i_clk);
    mem_gnt = 1'b0;
    #1 chk("rst_seq_resp_stall", 64'({mem_req, o_stall_mem}), 64'b01);
    i_reset = 1'b1;
    #1 chk("rst_mid_outputs", {flags(), mem_be, mem_addr}, 64'h0);
    @(negedge i_clk);
    i_reset = 1'b0; mem_rvalid = 1'b1;
    #1 chk("rst_stray_rvalid", {flags(), mem_be, mem_addr}, 64'h0);
    @(negedge i_clk);
    mem_rvalid = 1'b0;
    #1 chk("rst_after_idle", 64'(flags()), 64'h0);
    // Both requesters saturate the port; memory answers as fast as possible.
    @(negedge i_clk);
    {if_req, lsu_req, mem_gnt, mem_rvalid} = 4'b1111;
    for (int k = 0; k < 15; k++) begin
      #1;
`ifdef ARB_STARVE_GUARD_EN
      chk($sformatf("starve_arb%0d", k), 64'({if_gnt, lsu_gnt}), (k % 5 == 4) ? 64'b10 : 64'b01);
`else
      chk($sformatf("starve_arb%0d", k), 64'({if_gnt, lsu_gnt}), 64'b01);
`endif
      repeat (3) @(negedge i_clk);
    end
    {if_req, lsu_req, mem_gnt, mem_rvalid} = 4'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, number of consecutive lost IF arbitrations before IF is forced to win (range 1..15).
REQ-002 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_reset  in  1  asynchronous, active-high reset.
REQ-004 if_req  in  1  fetch request; held high until if_gnt.
REQ-005 if_addr  in  32  fetch word address.
REQ-006 if_gnt  out  1  one-cycle pulse; fetch command latched.
REQ-007 if_rvalid  out  1  one-cycle pulse; if_rdata valid.
REQ-008 if_rdata  out  32  fetch data.
REQ-009 lsu_req / lsu_we  in  1 / 1  load/store request, held until lsu_gnt; write enable.
REQ-010 lsu_addr / lsu_wdata  in  32 / 32  LSU address; store data.
REQ-011 lsu_be  in  4  store byte enables.
REQ-012 lsu_gnt / lsu_rvalid  out  1 / 1  grant pulse; response pulse (loads and stores).
REQ-013 lsu_rdata  out  32  load data.
REQ-014 mem_req / mem_we  out  1 / 1  memory command valid; write enable.
REQ-015 mem_addr / mem_wdata  out  32 / 32  registered command address; write data.
REQ-016 mem_be  out  4  byte enables; 4'hF for fetches.
REQ-017 mem_gnt  in  1  memory accepted the command this cycle.
REQ-018 mem_rvalid / mem_rdata  in  1 / 32  memory response pulse; read data.
REQ-019 o_stall_if / o_stall_mem  out  1 / 1  stall requests to the hazard unit for the IF and MEM stages.

Function
REQ-020 FSM states IDLE, REQ, RESP; one outstanding transaction maximum.
REQ-021 IDLE, no request: stay IDLE, mem_req=0.
REQ-022 IDLE, request(s) present: select winner, latch addr/wdata/be/we and owner into command registers, pulse the winner's gnt in that same cycle, go to REQ.
REQ-023 Priority: LSU beats IF, except when the starvation guard forces IF (REQ-037).
REQ-024 REQ: mem_req=1 with registered command; on mem_gnt go RESP, else stay REQ (command stable).
REQ-025 RESP: mem_req=0; on mem_rvalid pulse the owner's rvalid, drive its rdata = mem_rdata in that cycle, go IDLE.
REQ-026 Minimum latency request-to-rvalid: 3 cycles (gnt cycle 0, mem_req cycle 1 with mem_gnt, mem_rvalid earliest cycle 2, forwarded combinationally).
REQ-027 if_rvalid and lsu_rvalid never both high; non-owner rvalid stays 0.
REQ-028 if_rdata and lsu_rdata both carry mem_rdata; they are valid only when the corresponding rvalid is high.
REQ-029 Fetch command: mem_we=0, mem_be=4'hF.
REQ-030 mem_rvalid outside RESP is ignored; no state change.
REQ-031 mem_gnt outside REQ is ignored.
REQ-032 o_stall_if = if_req and not if_rvalid; o_stall_mem = lsu_req-or-LSU-owned-transaction and not lsu_rvalid; both combinational.
REQ-033 Requester may drop req after gnt; the transaction completes regardless.

Reset
REQ-034 While i_reset is high: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0; all gnt/rvalid=0; starvation counter=0; owner=IF.
REQ-035 Reset mid-transaction abandons it; a later mem_rvalid is ignored per REQ-030.
REQ-036 First arbitration possible in the first clock edge after reset deasserts.

Configuration
REQ-037 Macro ARB_STARVE_GUARD_EN defined: 4-bit counter increments each IDLE arbitration IF loses while if_req=1 and clears when IF wins; when counter == STARVE_LIMIT, IF wins the next arbitration.
REQ-038 Macro ARB_STARVE_GUARD_EN undefined: no counter; strict LSU priority always.

Verification
REQ-039 if_req=1 addr 0x100 alone, mem_gnt immediate, mem_rvalid next cycle data 0xDEADBEEF -> if_gnt cycle 0, mem_req cycle 1, if_rvalid+0xDEADBEEF cycle 2.
REQ-040 if_req and lsu_req (store 0x200, wdata 0x55AA, be 4'h3) same cycle -> lsu_gnt first, mem_we=1, mem_be=4'h3; if_gnt only after lsu_rvalid.
REQ-041 mem_gnt held low 5 cycles -> mem_req and command stable 5 cycles; o_stall_if high until if_rvalid.
REQ-042 With ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, lsu_req and if_req both held high -> 4 LSU grants, then 1 IF grant, repeating; without the macro -> IF never granted.
REQ-043 i_reset pulsed in RESP, then stray mem_rvalid -> no if_rvalid/lsu_rvalid; all outputs at reset values.
REQ-044 Stray mem_rvalid in IDLE with no request -> no rvalid out, state stays IDLE.
